// File: rtl/range_finder_multi_pkg.sv
// Shared types and encodings for the multi-statistic range finder.
package rf_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ERROR} state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_NOGO  = 2'd1;
  localparam logic [1:0] ERR_BOTH  = 2'd2;
  localparam logic [1:0] ERR_EMPTY = 2'd3;

  localparam logic [1:0] MODE_RANGE = 2'd0;
  localparam logic [1:0] MODE_MAX   = 2'd1;
  localparam logic [1:0] MODE_MIN   = 2'd2;
  localparam logic [1:0] MODE_MID   = 2'd3;
endpackage

// File: rtl/range_finder_multi_stat_sel.sv
// Combinational statistic select over a final min/max pair.
module rf_stat_sel
  import rf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_min,
  input  logic [WIDTH-1:0] i_max,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_stat
);
  // One extra bit so the midpoint sum cannot wrap before the shift.
  logic [WIDTH:0] w_sum;
  assign w_sum = {1'b0, i_max} + {1'b0, i_min};

  always_comb begin
    o_stat = i_max - i_min;
    case (i_mode)
      MODE_MAX: o_stat = i_max;
      MODE_MIN: o_stat = i_min;
      MODE_MID: o_stat = w_sum[WIDTH:1];
      default:  o_stat = i_max - i_min;
    endcase
  end
endmodule

// File: rtl/range_finder_multi.sv
// Windowed min/max tracker with saturating sample count, selectable statistic,
// one-cycle done pulse and encoded error state.
module range_finder_multi
  import rf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  input  logic             go,
  input  logic             finish,
  input  logic             clear,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] sample_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_err_code, w_err_nxt;
  logic [WIDTH-1:0] r_min, r_max, r_result;
  logic [CNT_W-1:0] r_cnt, r_scount;
  logic             r_busy, r_done, r_error;
  logic             r_pend;
  logic [1:0]       r_mode_l;
  logic             w_init, w_fin;
  logic [WIDTH-1:0] w_min_nxt, w_max_nxt, w_stat;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Accumulator update including the current sample; also used for the finish cycle.
  always_comb begin
    w_min_nxt = r_min;
    w_max_nxt = r_max;
    w_cnt_nxt = r_cnt;
    if (data_valid) begin
      if (data_in < r_min) w_min_nxt = data_in;
      if (data_in > r_max) w_max_nxt = data_in;
      if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err_code;
    w_init      = 1'b0;
    w_fin       = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_err_nxt   = ERR_NONE;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERROR: begin
          if (go && !finish) begin
            w_state_nxt = ST_RUN;
            w_err_nxt   = ERR_NONE;
            w_init      = 1'b1;
          end else if (go && finish) begin
            w_state_nxt = ST_ERROR;
            w_err_nxt   = ERR_BOTH;
          end else if (finish) begin
            w_state_nxt = ST_ERROR;
            w_err_nxt   = ERR_NOGO;
          end
        end
        ST_RUN: begin
          // Count saturates rather than wraps, so zero here means no samples.
          if (finish) begin
            if (w_cnt_nxt == '0) begin
              w_state_nxt = ST_ERROR;
              w_err_nxt   = ERR_EMPTY;
            end else begin
              w_state_nxt = ST_IDLE;
              w_fin       = 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  rf_stat_sel #(.WIDTH(WIDTH)) u_stat (
    .i_min  (r_min),
    .i_max  (r_max),
    .i_mode (r_mode_l),
    .o_stat (w_stat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_err_code <= ERR_NONE;
      r_min      <= '1;
      r_max      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_scount   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_pend     <= 1'b0;
      r_mode_l   <= MODE_RANGE;
    end else begin
      r_state    <= w_state_nxt;
      r_err_code <= w_err_nxt;
      r_busy     <= (w_state_nxt == ST_RUN);
      r_error    <= (w_state_nxt == ST_ERROR);
      r_done     <= 1'b0;
      r_pend     <= w_fin;
      if (w_fin) r_mode_l <= mode;
      if (clear) begin
        r_result <= '0;
        r_scount <= '0;
        r_min    <= '1;
        r_max    <= '0;
        r_cnt    <= '0;
        r_pend   <= 1'b0;
      end else begin
        if (w_init) begin
          r_min <= data_valid ? data_in : '1;
          r_max <= data_valid ? data_in : '0;
          r_cnt <= data_valid ? CNT_W'(1) : '0;
        end else if (r_state == ST_RUN) begin
          r_min <= w_min_nxt;
          r_max <= w_max_nxt;
          r_cnt <= w_cnt_nxt;
        end
        // Accumulators hold the final window one cycle after finish.
        if (r_pend) begin
          r_result <= w_stat;
          r_scount <= r_cnt;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign result       = r_result;
  assign sample_count = r_scount;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign err_code     = r_err_code;
endmodule

// File: tb/tb_range_finder_multi.sv
// Directed bench for range_finder_multi: default build plus a CNT_W=3 build on shared stimulus.
module tb_range_finder_multi;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0, go = 1'b0, finish = 1'b0, clear = 1'b0;
  logic [1:0] mode = '0;

  logic [7:0] result, result3, sample_count;
  logic [2:0] sample_count3;
  logic       busy, done, error, busy3, done3, error3;
  logic [1:0] err_code, err_code3;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  range_finder_multi #(.WIDTH(8), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .go(go), .finish(finish), .clear(clear), .mode(mode),
    .result(result), .sample_count(sample_count), .busy(busy),
    .done(done), .error(error), .err_code(err_code)
  );

  range_finder_multi #(.WIDTH(8), .CNT_W(3)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .go(go), .finish(finish), .clear(clear), .mode(mode),
    .result(result3), .sample_count(sample_count3), .busy(busy3),
    .done(done3), .error(error3), .err_code(err_code3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic v, input logic [7:0] d);
    data_valid = v;
    data_in    = d;
    tick();
  endtask

  // Window 20 | 50 5 30 | finish with 12; leaves the bench right after the finish edge.
  task automatic basic_window(input logic [1:0] m);
    go = 1'b1; smp(1'b1, 8'd20);
    go = 1'b0;
    smp(1'b1, 8'd50);
    smp(1'b1, 8'd5);
    smp(1'b1, 8'd30);
    finish = 1'b1; mode = m;
    smp(1'b1, 8'd12);
    finish = 1'b0; data_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_result", result, 0);
    chk("rst_count", sample_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_errcode", err_code, 0);
    #10 rst_n = 1'b1;
    tick();

    // Basic range, with latency check on done
    basic_window(2'd0);
    chk("basic_done_early", done, 0);
    chk("basic_busy_after_fin", busy, 0);
    tick();
    chk("basic_result", result, 45);
    chk("basic_count", sample_count, 5);
    chk("basic_done", done, 1);
    chk("basic_error", error, 0);
    chk("basic_count_c3", sample_count3, 5);
    tick();
    chk("basic_done_pulse", done, 0);
    chk("basic_hold", result, 45);

    basic_window(2'd1); tick();
    chk("mode_max", result, 50);
    basic_window(2'd2); tick();
    chk("mode_min", result, 5);
    basic_window(2'd3); tick();
    chk("mode_mid", result, 27);
    mode = 2'd1; tick(); tick();
    chk("mode_change_hold", result, 27);

    // Errors
    finish = 1'b1; tick(); finish = 1'b0;
    chk("nogo_error", error, 1);
    chk("nogo_code", err_code, 1);
    go = 1'b1; finish = 1'b1; tick(); go = 1'b0; finish = 1'b0;
    chk("both_code", err_code, 2);
    chk("both_error", error, 1);
    go = 1'b1; tick(); go = 1'b0;
    chk("rego_busy", busy, 1);
    chk("rego_error", error, 0);
    chk("rego_code", err_code, 0);
    smp(1'b0, 8'd99);
    finish = 1'b1; tick(); finish = 1'b0;
    chk("empty_code", err_code, 3);
    chk("empty_error", error, 1);
    tick();
    chk("empty_done", done, 0);
    chk("empty_result_kept", result, 27);

    // Extremes
    go = 1'b1; smp(1'b1, 8'd0); go = 1'b0;
    smp(1'b1, 8'd255);
    finish = 1'b1; mode = 2'd0; smp(1'b0, 8'd0); finish = 1'b0;
    tick();
    chk("ext_range", result, 255);
    chk("ext_count", sample_count, 2);
    chk("ext_error", error, 0);
    go = 1'b1; smp(1'b1, 8'd255); go = 1'b0;
    smp(1'b1, 8'd0);
    finish = 1'b1; mode = 2'd3; smp(1'b0, 8'd0); finish = 1'b0;
    tick();
    chk("ext_mid", result, 127);

    // Saturation: 10 valid samples 10..100
    go = 1'b1; smp(1'b1, 8'd10); go = 1'b0;
    for (int i = 2; i <= 10; i++) smp(1'b1, 8'(i * 10));
    finish = 1'b1; mode = 2'd0; smp(1'b0, 8'd0); finish = 1'b0;
    tick();
    chk("sat_count_c8", sample_count, 10);
    chk("sat_count_c3", sample_count3, 7);
    chk("sat_range_c3", result3, 90);

    // Invalid cycles ignored
    go = 1'b1; smp(1'b1, 8'd100); go = 1'b0;
    smp(1'b0, 8'd0);
    smp(1'b0, 8'd250);
    smp(1'b1, 8'd120);
    finish = 1'b1; mode = 2'd0; smp(1'b0, 8'd3); finish = 1'b0;
    tick();
    chk("dv_range", result, 20);
    chk("dv_count", sample_count, 2);

    // Async reset mid-run
    go = 1'b1; smp(1'b1, 8'd10); go = 1'b0;
    smp(1'b1, 8'd60);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", result, 0);
    chk("arst_count", sample_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_error", error | done, 0);
    #2 rst_n = 1'b1;
    data_valid = 1'b0;
    tick();
    go = 1'b1; smp(1'b1, 8'd40); go = 1'b0;
    smp(1'b1, 8'd60);
    finish = 1'b1; mode = 2'd0; smp(1'b0, 8'd0); finish = 1'b0;
    tick();
    chk("post_rst_range", result, 20);
    chk("post_rst_count", sample_count, 2);

    // Clear during run
    go = 1'b1; smp(1'b1, 8'd7); go = 1'b0;
    chk("clr_pre_busy", busy, 1);
    clear = 1'b1; smp(1'b0, 8'd0); clear = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_result", result, 0);
    chk("clr_count", sample_count, 0);
    finish = 1'b1; tick(); finish = 1'b0;
    chk("clr_nogo_error", error, 1);
    chk("clr_nogo_code", err_code, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/range_finder_multi.md
Name: range_finder_multi

Overview:
- Parametrised successor to the team's single-mode range finder.
- Tracks running min/max over a go..finish measurement window of qualified samples, with a saturating sample counter.
- Reports one of four selectable statistics, plus a done pulse and an encoded error.
- Sits behind the top-level wrapper: data on dedicated inputs, control on bidirectional pins, result on dedicated outputs.

Parameters:
- WIDTH, 8: sample/result width in bits (>=2).
- CNT_W, 8: sample counter width; counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- data_in  input  WIDTH  unsigned sample.
- data_valid  input  1  sample qualifier; sample used only when high.
- go  input  1  start window.
- finish  input  1  end window.
- clear  input  1  synchronous return to IDLE, clears error/result.
- mode  input  2  statistic select: 0 range, 1 max, 2 min, 3 midpoint.
- result  output  WIDTH  registered statistic.
- sample_count  output  CNT_W  samples in last completed window.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on completion.
- error  output  1  high in ERROR.
- err_code  output  2  0 none, 1 finish-without-go, 2 go&finish together, 3 empty window.

Behaviour:
- Reset (rst_n low, async): state IDLE; min=all-ones; max=0; count=0; result=0; sample_count=0; busy=0; done=0; error=0; err_code=0.
- States: IDLE, RUN, ERROR. clear has priority over all transitions except reset: next state IDLE, err_code=0, result=0, sample_count=0, done=0.
- IDLE:
  - go&!finish -> RUN. min/max/count initialise; a data_valid sample in the go cycle is counted (min=max=data_in, count=1).
  - go&finish -> ERROR, code 2.
  - finish&!go -> ERROR, code 1.
- RUN:
  - Each data_valid cycle: min=min(min,data_in), max=max(max,data_in), count+1 saturating at 2^CNT_W-1.
  - go while in RUN is ignored; no restart.
  - finish -> IDLE. The finish-cycle sample (if data_valid) is included.
    - If the final count is 0: -> ERROR, code 3, result unchanged.
    - Otherwise, at the next edge: result = stat(mode sampled in finish cycle); sample_count = final count; done=1 for exactly one cycle.
  - go&finish in RUN is treated as finish (go ignored).
- ERROR:
  - error=1, err_code held.
  - go&!finish -> RUN, clears error/err_code, initialises as from IDLE.
  - finish or go&finish -> stay in ERROR; code updated per the IDLE rules.
- Statistics, computed from final min/max including the finish-cycle sample:
  - range = max-min, WIDTH bits, never negative.
  - midpoint = (max+min)>>1, computed WIDTH+1 wide, truncated to WIDTH.
- Latency: finish at edge N -> result/done/sample_count visible after edge N+1. Error is visible after the edge that detects it.
- result/sample_count hold between windows. mode changes after finish do not affect the held result.
- busy = (state==RUN), registered.

Decomposition:
- Shared package rf_pkg: state enum (IDLE, RUN, ERROR), err_code constants (ERR_NONE, ERR_NOGO, ERR_BOTH, ERR_EMPTY), mode constants (MODE_RANGE, MODE_MAX, MODE_MIN, MODE_MID).
- One sub-module, rf_stat_sel: combinational, parametrised on WIDTH; takes min, max, mode and returns the statistic.
- FSM, accumulators and output registers stay in range_finder_multi.

Test Plan:
- Basic range: go with data 20 valid; samples 50, 5, 30; finish with 12 valid; mode 0 -> result 45, sample_count 5, done one cycle after finish, error 0.
- Modes: same window, repeated with mode 1/2/3 at finish -> 50 / 5 / 27. mode changed to 1 after done -> result stays 27.
- Errors:
  - finish in IDLE -> error=1, err_code 1.
  - Then go&finish -> err_code 2.
  - Then go alone -> busy=1, error=0.
  - go, no valid samples, finish -> err_code 3, done=0.
- Boundaries:
  - WIDTH=8: samples 0 and 255 -> range 255, midpoint 127.
  - CNT_W=3: window with 10 valid samples -> sample_count 7.
  - data_valid low cycles are ignored.
- Reset/clear mid-operation:
  - rst_n asserted low asynchronously mid-RUN -> all outputs 0 immediately, next go starts clean.
  - clear during RUN -> IDLE, a later finish without go gives err_code 1.
